// File: rtl/uart_tx_fetch_if.sv
// FIFO read-side handshake between an upstream FIFO and the UART transmitter.
// master = transmitter (issues load), slave = FIFO (supplies empty/din/din_valid).
interface uart_tx_fetch_if #(
  parameter int WIDTH = 8
) ();
  logic             empty;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             din_valid;

  modport master (
    input  empty,
    input  din,
    input  din_valid,
    output load
  );

  modport slave (
    output empty,
    output din,
    output din_valid,
    input  load
  );
endinterface

// File: rtl/uart_tx_fetch.sv
// UART transmitter that pulls each word from an upstream FIFO before framing it.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_fetch #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 434
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_fetch_if.master       fifo,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(CLK_DIV - 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state;
  logic [CW-1:0]    baud;
  logic [BW-1:0]    bitcnt;
  logic [WIDTH-1:0] shreg;
`ifdef UART_TX_PARITY_EN
  logic             par;
`endif

  wire baud_end = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      txd       <= 1'b1;
      fifo.load <= 1'b0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      baud      <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
`ifdef UART_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      fifo.load <= 1'b0;
      tx_done   <= 1'b0;
      baud      <= '0;
      case (state)
        IDLE: begin
          if (!fifo.empty) begin
            state     <= FETCH;
            fifo.load <= 1'b1;
            busy      <= 1'b1;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          // No read data means the FIFO lost the race; drop back without a frame.
          if (fifo.din_valid) begin
            shreg <= fifo.din;
`ifdef UART_TX_PARITY_EN
            par   <= ^fifo.din;
`endif
            txd   <= 1'b0;
            state <= START;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        START: begin
          baud <= baud_end ? '0 : baud + 1'b1;
          if (baud_end) begin
            bitcnt <= '0;
            txd    <= shreg[0];
            shreg  <= shreg >> 1;
            state  <= DATA;
          end
        end
        DATA: begin
          baud <= baud_end ? '0 : baud + 1'b1;
          if (baud_end) begin
            if (bitcnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              txd   <= par;
              state <= PARITY;
`else
              txd   <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bitcnt <= bitcnt + 1'b1;
              txd    <= shreg[0];
              shreg  <= shreg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          baud <= baud_end ? '0 : baud + 1'b1;
          if (baud_end) begin
            txd   <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          baud <= baud_end ? '0 : baud + 1'b1;
          // Registered pulse: set one cycle early so it lines up with the last stop cycle.
          if (baud == BAUD_PRE) tx_done <= 1'b1;
          if (baud_end) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          txd   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fetch.md
UART_TX_FETCH -- requirements
Module: uart_tx_fetch

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame.
REQ-002 SHALL have parameter CLK_DIV, default 434, clock cycles per bit (50 MHz / 115200); legal range 2..65535.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port empty  input  1  upstream FIFO empty flag.
REQ-006 SHALL have port load  output  1  read request to upstream FIFO.
REQ-007 SHALL have port din  input  WIDTH  FIFO read data, qualified by din_valid.
REQ-008 SHALL have port din_valid  input  1  FIFO read-data valid, one cycle after an accepted load.
REQ-009 SHALL have port txd  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse at end of stop bit.

Function
REQ-012 SHALL implement states IDLE, FETCH, WAIT, START, DATA, PARITY, STOP.
REQ-013 IDLE: when empty=0, SHALL go to FETCH; otherwise stay.
REQ-014 FETCH: SHALL drive load=1 for exactly this one cycle, then go to WAIT; load SHALL be 0 in every other state.
REQ-015 WAIT: if din_valid=1, SHALL latch din into the shift register and go to START; if din_valid=0, SHALL return to IDLE without transmitting (lost-race guard).
REQ-016 START, DATA, PARITY, STOP SHALL each hold txd for exactly CLK_DIV cycles per bit, timed by a baud counter cleared on every state entry.
REQ-017 START SHALL drive txd=0.
REQ-018 DATA SHALL send WIDTH bits LSB first, tracked by a bit counter of width ceil(log2(WIDTH))+1; it exits after bit WIDTH-1.
REQ-019 STOP SHALL drive txd=1; on its last cycle it SHALL pulse tx_done and go to IDLE.
REQ-020 Back-to-back frames: the minimum gap between the stop-bit end and the next start-bit begin SHALL be 3 cycles (IDLE, FETCH, WAIT).
REQ-021 din_valid arriving in any state other than WAIT SHALL be ignored.
REQ-022 Changes on empty during a frame SHALL NOT affect the frame in progress.
REQ-023 busy SHALL be 1 in FETCH, WAIT, START, DATA, PARITY and STOP.

Reset
REQ-024 While rst=1 at a clock edge, state SHALL become IDLE, txd=1, load=0, busy=0, tx_done=0, and the counters and shift register SHALL clear.
REQ-025 Reset asserted mid-frame SHALL abort the frame; txd SHALL be 1 from the next edge onward, and no FIFO read is re-issued for the aborted word.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: PARITY state SHALL follow DATA and drive txd to the even-parity bit (XOR of the WIDTH data bits) for CLK_DIV cycles before STOP.
REQ-027 Macro UART_TX_PARITY_EN undefined: PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification
REQ-028 Reset sequence: rst=1 for 3 cycles, then release with empty=1 -> txd=1, load=0, busy=0 indefinitely.
REQ-029 Single byte 0xA5 with CLK_DIV=4 and no parity -> load pulses once; txd sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; tx_done pulses once; frame length 40 cycles.
REQ-030 Two bytes 0x00 then 0xFF queued with empty=0 throughout -> exactly 2 load pulses, 3-cycle gap between frames, correct bit order in both frames.
REQ-031 UART_TX_PARITY_EN defined, byte 0x07 -> parity bit 1 before stop; byte 0x03 -> parity bit 0; frame length 11 bits.
REQ-032 load accepted but din_valid withheld -> FSM returns to IDLE, txd stays 1, and there is no tx_done pulse.
REQ-033 rst=1 asserted in the middle of the DATA bits of 0x55 -> txd=1 from the next edge and busy=0; the next queued byte is sent as a complete, correct frame.
